// File: rtl/homing_pkg.sv
// homing_pkg: shared constants for the light-homing steering block.
// Motor command codes, FSM state codes and default cycle counts.
package homing_pkg;

    localparam int CLK_HZ = 12_000_000;

    localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;
    localparam int DEF_TURN_MIN_CYCLES = CLK_HZ / 10;
    localparam int DEF_ARRIVE_CYCLES   = CLK_HZ / 2;

    localparam logic [1:0] MOT_STOP = 2'b00;
    localparam logic [1:0] MOT_FWD  = 2'b01;
    localparam logic [1:0] MOT_BACK = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SEARCH     = 3'd1,
        ST_FORWARD    = 3'd2,
        ST_TURN_LEFT  = 3'd3,
        ST_TURN_RIGHT = 3'd4,
        ST_ARRIVED    = 3'd5
    } state_t;

    // Steering choice from the two filtered light bits.
    function automatic state_t steer_decode(input logic fl, input logic fr);
        state_t s;
        unique case ({fl, fr})
            2'b11:   s = ST_FORWARD;
            2'b10:   s = ST_TURN_LEFT;
            2'b01:   s = ST_TURN_RIGHT;
            default: s = ST_SEARCH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: 2-flop synchronizer followed by a stability filter.
// dout follows din only after DEBOUNCE_CYCLES consecutive differing samples.
module sync_debounce
    import homing_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CLAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          filt;
    logic [CW-1:0] cnt;

    // Metastability guard on the asynchronous comparator input.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    // Count disagreement run; flip the filtered bit when it is long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (s2 == filt) begin
            cnt <= '0;
        end else if (cnt == CLAST) begin
            filt <= s2;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign dout = filt;

endmodule

// File: rtl/homing_steer.sv
// homing_steer: steers two servos toward a light source while enabled.
// Filtered LDR bits drive a small FSM; outputs decode from the state register.
module homing_steer
    import homing_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TURN_MIN_CYCLES = DEF_TURN_MIN_CYCLES,
    parameter int ARRIVE_CYCLES   = DEF_ARRIVE_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       light_left,
    input  logic       light_right,
    output logic [1:0] motor_left,
    output logic [1:0] motor_right,
    output logic       arrived,
    output logic [2:0] state_dbg
);

    localparam int DW = (TURN_MIN_CYCLES > 1) ? $clog2(TURN_MIN_CYCLES) : 1;
    localparam int AW = (ARRIVE_CYCLES > 1) ? $clog2(ARRIVE_CYCLES) : 1;
    localparam logic [DW-1:0] DLAST = DW'(TURN_MIN_CYCLES - 1);
    localparam logic [AW-1:0] ALAST = AW'(ARRIVE_CYCLES - 1);

    logic          fl;
    logic          fr;
    state_t        state;
    state_t        nxt;
    logic [DW-1:0] dwell;
    logic [DW-1:0] dwell_nxt;
    logic [AW-1:0] arr;
    logic [AW-1:0] arr_nxt;

    sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_left (
        .clk (clk),
        .rst (rst),
        .din (light_left),
        .dout(fl)
    );

    sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_right (
        .clk (clk),
        .rst (rst),
        .din (light_right),
        .dout(fr)
    );

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            dwell <= '0;
            arr   <= '0;
        end else begin
            state <= nxt;
            dwell <= dwell_nxt;
            arr   <= arr_nxt;
        end
    end

    // Next state; counters advance only while staying put, else clear.
    always_comb begin
        nxt       = state;
        dwell_nxt = '0;
        arr_nxt   = '0;
        if (!enable) begin
            nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    nxt = ST_SEARCH;
                end
                ST_SEARCH: begin
                    nxt = steer_decode(fl, fr);
                end
                ST_FORWARD: begin
                    if (fl && fr) begin
                        if (arr == ALAST) begin
                            nxt = ST_ARRIVED;
                        end else begin
                            arr_nxt = arr + 1'b1;
                        end
                    end else begin
                        nxt = steer_decode(fl, fr);
                    end
                end
                ST_TURN_LEFT, ST_TURN_RIGHT: begin
                    if (dwell == DLAST) begin
                        nxt = steer_decode(fl, fr);
                    end else begin
                        dwell_nxt = dwell + 1'b1;
                    end
                end
                ST_ARRIVED: begin
                    nxt = ST_ARRIVED;
                end
                default: begin
                    nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Motor commands and flags decoded from the current state.
    always_comb begin
        motor_left  = MOT_STOP;
        motor_right = MOT_STOP;
        arrived     = 1'b0;
        unique case (state)
            ST_SEARCH: begin
                motor_left  = MOT_BACK;
                motor_right = MOT_FWD;
            end
            ST_FORWARD: begin
                motor_left  = MOT_FWD;
                motor_right = MOT_FWD;
            end
            ST_TURN_LEFT: begin
                motor_right = MOT_FWD;
            end
            ST_TURN_RIGHT: begin
                motor_left = MOT_FWD;
            end
            ST_ARRIVED: begin
                arrived = 1'b1;
            end
            default: begin
                motor_left  = MOT_STOP;
                motor_right = MOT_STOP;
            end
        endcase
    end

    assign state_dbg = state;

endmodule

// File: doc/homing_steer.md
Name: homing_steer

Overview:
- Downstream consumer of the homing delay stage's `enable` output.
- While enabled, reads two light-sensor comparator bits (left/right LDR) and steers the two continuous-rotation servos toward the light source.
- Stops and flags arrival once the source is centred and held.
- Motor command outputs feed the existing per-servo PWM drivers.

Parameters:
- DEBOUNCE_CYCLES, 120000 (10 ms @ 12 MHz): consecutive stable synchronized samples required before a filtered sensor bit changes.
- TURN_MIN_CYCLES, 1200000 (100 ms): minimum dwell in a turn state before re-evaluating sensors.
- ARRIVE_CYCLES, 6000000 (500 ms): consecutive cycles in FORWARD with both sensors lit before declaring arrival.

Ports:
- clk  in  1  system clock (12 MHz)
- rst  in  1  synchronous, active-high reset
- enable  in  1  from homing delay stage; 1 = homing behaviour allowed
- light_left  in  1  asynchronous comparator output; 1 = light detected
- light_right  in  1  asynchronous comparator output; 1 = light detected
- motor_left  out  2  servo command: 00 stop, 01 forward, 10 backward (11 never driven)
- motor_right  out  2  same encoding
- arrived  out  1  1 while in ARRIVED
- state_dbg  out  3  current FSM state encoding, for LEDs/debug

Behaviour:
- Clocking and reset:
  - One clock domain. All state changes on rising clk.
  - rst has priority over everything.
- Reset values:
  - FSM = IDLE.
  - motor_left = motor_right = 00; arrived = 0; state_dbg = IDLE code.
  - Filtered sensor bits = 0; all counters = 0; synchronizer flops = 0.
- Synchronizer:
  - Each light input passes through 2 flops.
- Debounce (per sensor):
  - Count cycles where the synchronized bit differs from the filtered bit.
  - Counter clears whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the bits still different: filtered is updated and the counter clears.
  - Net latency from input change to filtered change = 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES never reaches the filtered bit.
- FSM states (3-bit codes):
  - IDLE = 0: motors 00/00.
  - SEARCH = 1: spin in place; left 10, right 01.
  - FORWARD = 2: 01/01.
  - TURN_LEFT = 3: left 00, right 01.
  - TURN_RIGHT = 4: left 01, right 00.
  - ARRIVED = 5: 00/00, arrived = 1.
- Outputs are decoded from the state register. Outputs change in the same cycle the state register changes, so the filtered-change-to-output latency is 1 clock.
- Transitions (fL/fR = filtered bits), evaluated every cycle:
  - Any state, enable = 0: go to IDLE next cycle. All counters clear.
  - IDLE, enable = 1: go to SEARCH.
  - SEARCH / FORWARD / TURN_* (after dwell), decoded from fL/fR:
    - fL & fR: FORWARD.
    - fL only: TURN_LEFT.
    - fR only: TURN_RIGHT.
    - neither: SEARCH.
  - TURN_*: the dwell counter starts at 0 on entry. No sensor evaluation until the counter reaches TURN_MIN_CYCLES-1. enable = 0 still exits immediately.
  - FORWARD: the arrive counter increments while fL & fR, and clears on any other sensor combination. On reaching ARRIVE_CYCLES-1, go to ARRIVED.
  - ARRIVED: sticky. Ignores sensors. Leaves only via enable = 0 (to IDLE).
- Simultaneous events:
  - enable falling in the same cycle as an arrive or dwell terminal count: IDLE wins.
  - Both sensors changing in the same cycle: decoded jointly; no intermediate turn state.
- Counter widths = $clog2 of the respective parameter. Counters saturate-free; each clears on state exit.
- Reset mid-operation returns everything to reset values on the next edge regardless of state.

Decomposition:
- Package homing_pkg:
  - Motor command constants (MOT_STOP, MOT_FWD, MOT_BACK).
  - FSM state encodings.
  - Default cycle constants derived from CLK_HZ = 12_000_000.
- Sub-module sync_debounce (params DEBOUNCE_CYCLES; ports clk, rst, din, dout): 2-flop synchronizer plus debounce counter. Instantiated once per sensor.

Test Plan (sim params DEBOUNCE_CYCLES=4, TURN_MIN_CYCLES=8, ARRIVE_CYCLES=16):
- Reset, enable = 0 -> motors 00/00, arrived = 0, state_dbg = 0. Assert enable -> state_dbg = 1 and motors 10/01 exactly one cycle later.
- In SEARCH, raise light_left only -> state_dbg = 3 and motors 00/01 exactly 7 cycles after the input edge (2 + 4 + 1).
- Pulse light_right high for 3 cycles during SEARCH -> no state change, motors remain 10/01.
- In TURN_LEFT, raise light_right on entry cycle + 1 -> state stays 3 until dwell completes, then FORWARD (01/01).
- In FORWARD, hold both lit -> ARRIVED (arrived = 1, motors 00/00) after 16 cycles. Drop one sensor at cycle 10 instead -> counter clears, no arrival.
- In ARRIVED, drop enable -> IDLE next cycle. Assert rst mid-TURN_RIGHT -> all outputs at reset values next edge.
